// File: rtl/bcd_pkg.sv
// Shared types, constants and helpers for the sequential binary-to-BCD converter.
// Optional leading-zero blanking is enabled by defining BIN2BCD_BLANK_EN.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Digit code the display driver renders as all segments off.
  localparam logic [3:0] BCD_BLANK = 4'hF;

  function automatic logic [3:0] bcd_digit_adj(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  // Decimal digits required to show 2**bin_w-1 without overflow.
  function automatic int digits_needed(input int bin_w);
    longint unsigned v;
    int n;
    v = (64'd1 << bin_w) - 64'd1;
    n = 0;
    do begin
      n = n + 1;
      v = v / 64'd10;
    end while (v != 64'd0);
    return n;
  endfunction

endpackage

// File: rtl/bcd_adj_row.sv
// Combinational add-3 correction applied independently to every digit of the
// BCD accumulator; no carry propagates between digits.
module bcd_adj_row
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  logic [4*DIGITS-1:0] bcd_in,
  output logic [4*DIGITS-1:0] bcd_adj
);

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign bcd_adj[4*gi +: 4] = bcd_digit_adj(bcd_in[4*gi +: 4]);
    end
  endgenerate

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-packed-BCD converter with valid/ready on both sides.
// Define BIN2BCD_BLANK_EN to replace leading zero digits with the blank code.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BIN_W-1:0]    in_bin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] out_bcd,
  output logic                out_ovf,
  output logic                busy
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  generate
    if (BIN_W < 4 || BIN_W > 32) begin : g_bad_bin_w
      $error("bin2bcd_seq: BIN_W=%0d outside legal range 4..32", BIN_W);
    end
    if (DIGITS < 1 || DIGITS > 10) begin : g_bad_digits
      $error("bin2bcd_seq: DIGITS=%0d outside legal range 1..10", DIGITS);
    end
    if (DIGITS < digits_needed(BIN_W)) begin : g_ovf_possible
      $info("bin2bcd_seq: DIGITS=%0d below %0d, large inputs will flag out_ovf",
            DIGITS, digits_needed(BIN_W));
    end
  endgenerate

  state_t             state_reg, state_next;
  logic [BIN_W-1:0]   bin_reg;
  logic [BCD_W-1:0]   bcd_reg;
  logic               ovf_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [BCD_W-1:0]   out_bcd_reg;
  logic               out_ovf_reg;

  logic [BCD_W-1:0]       bcd_adj;
  logic [BCD_W+BIN_W-1:0] shift_word;
  logic [BCD_W-1:0]       bcd_shifted;
  logic [BIN_W-1:0]       bin_shifted;
  logic                   ovf_shifted;
  logic                   last_shift;
  logic [BCD_W-1:0]       result_bcd;

  bcd_adj_row #(
    .DIGITS (DIGITS)
  ) u_adj_row (
    .bcd_in  (bcd_reg),
    .bcd_adj (bcd_adj)
  );

  // Adjusted accumulator and remaining binary bits shift left as one word.
  assign shift_word  = {bcd_adj[BCD_W-2:0], bin_reg, 1'b0};
  assign bcd_shifted = shift_word[BCD_W+BIN_W-1:BIN_W];
  assign bin_shifted = shift_word[BIN_W-1:0];
  assign ovf_shifted = ovf_reg | bcd_adj[BCD_W-1];
  assign last_shift  = (cnt_reg == CNT_LAST);

`ifdef BIN2BCD_BLANK_EN
  // lead_zero[k]: digits k..DIGITS-1 are all zero. Digit 0 always shows.
  logic [DIGITS:1] lead_zero;
  assign lead_zero[DIGITS] = 1'b1;
  assign result_bcd[3:0]   = bcd_shifted[3:0];

  genvar gi;
  generate
    for (gi = DIGITS - 1; gi >= 1; gi--) begin : g_blank
      assign lead_zero[gi] = lead_zero[gi+1] & (bcd_shifted[4*gi +: 4] == 4'd0);
      assign result_bcd[4*gi +: 4] = (lead_zero[gi] && !ovf_shifted) ? BCD_BLANK
                                                                    : bcd_shifted[4*gi +: 4];
    end
  endgenerate
`else
  assign result_bcd = bcd_shifted;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_shift) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_reg     <= '0;
      bcd_reg     <= '0;
      ovf_reg     <= 1'b0;
      cnt_reg     <= '0;
      out_bcd_reg <= '0;
      out_ovf_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            bin_reg <= in_bin;
            bcd_reg <= '0;
            ovf_reg <= 1'b0;
            cnt_reg <= '0;
          end
        end
        SHIFT: begin
          bin_reg <= bin_shifted;
          bcd_reg <= bcd_shifted;
          ovf_reg <= ovf_shifted;
          cnt_reg <= cnt_reg + 1'b1;
          // Result registers load once and stay frozen for the whole DONE phase.
          if (last_shift) begin
            out_bcd_reg <= result_bcd;
            out_ovf_reg <= ovf_shifted;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign out_bcd = out_bcd_reg;
  assign out_ovf = out_ovf_reg;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq across three parameter sets.
// Expected values follow the BIN2BCD_BLANK_EN setting of the build.
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // Instance A: BIN_W=8, DIGITS=3
  logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b1, a_out_ovf, a_busy;
  logic [7:0]  a_in_bin = '0;
  logic [11:0] a_out_bcd;
  // Instance B: BIN_W=8, DIGITS=2
  logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1, b_out_ovf, b_busy;
  logic [7:0]  b_in_bin = '0;
  logic [7:0]  b_out_bcd;
  // Instance C: BIN_W=16, DIGITS=5
  logic        c_in_valid = 1'b0, c_in_ready, c_out_valid, c_out_ready = 1'b1, c_out_ovf, c_busy;
  logic [15:0] c_in_bin = '0;
  logic [19:0] c_out_bcd;

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_bin(a_in_bin),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_bcd(a_out_bcd),
    .out_ovf(a_out_ovf), .busy(a_busy));

  bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_bin(b_in_bin),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_bcd(b_out_bcd),
    .out_ovf(b_out_ovf), .busy(b_busy));

  bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) u_dut_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_bin(c_in_bin),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_bcd(c_out_bcd),
    .out_ovf(c_out_ovf), .busy(c_busy));

  function automatic logic get_in_ready(input int sel);
    return (sel == 0) ? a_in_ready : (sel == 1) ? b_in_ready : c_in_ready;
  endfunction
  function automatic logic get_out_valid(input int sel);
    return (sel == 0) ? a_out_valid : (sel == 1) ? b_out_valid : c_out_valid;
  endfunction
  function automatic logic get_busy(input int sel);
    return (sel == 0) ? a_busy : (sel == 1) ? b_busy : c_busy;
  endfunction
  function automatic logic get_ovf(input int sel);
    return (sel == 0) ? a_out_ovf : (sel == 1) ? b_out_ovf : c_out_ovf;
  endfunction
  function automatic logic [19:0] get_bcd(input int sel);
    return (sel == 0) ? 20'(a_out_bcd) : (sel == 1) ? 20'(b_out_bcd) : c_out_bcd;
  endfunction

  task automatic drive_in(input int sel, input logic v, input logic [15:0] bin);
    case (sel)
      0: begin a_in_valid = v; a_in_bin = bin[7:0]; end
      1: begin b_in_valid = v; b_in_bin = bin[7:0]; end
      default: begin c_in_valid = v; c_in_bin = bin; end
    endcase
  endtask

  // One conversion with out_ready high; lat counts clocks from the capture
  // edge (inclusive) to the edge that raises out_valid. Capped at 200.
  task automatic run_conv(input int sel, input logic [15:0] v, output logic [19:0] bcd,
                          output logic ovf, output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    drive_in(sel, 1'b1, v);
    @(posedge clk); #1;
    drive_in(sel, 1'b0, v);
    lat = 1;
    while (get_out_valid(sel) !== 1'b1 && lat < 200) begin
      if (get_busy(sel) === 1'b1) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    bcd = get_bcd(sel);
    ovf = get_ovf(sel);
    @(posedge clk); #1;
    $display("conv sel=%0d in=%0d bcd=%h ovf=%b lat=%0d busy=%0d", sel, v, bcd, ovf, lat, busy_cnt);
  endtask

  task automatic test_reset;
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (get_in_ready(s) !== 1'b1 || get_out_valid(s) !== 1'b0 || get_busy(s) !== 1'b0 ||
          get_bcd(s) !== 20'h0 || get_ovf(s) !== 1'b0) begin
        errors++;
        $display("FAIL reset_state sel=%0d: got rdy=%b vld=%b busy=%b bcd=%h ovf=%b, want 1 0 0 0 0",
                 s, get_in_ready(s), get_out_valid(s), get_busy(s), get_bcd(s), get_ovf(s));
      end
    end
  endtask

  task automatic test_max_value;
    logic [19:0] bcd; logic ovf; int lat, bc;
    run_conv(0, 16'hFF, bcd, ovf, lat, bc);
    checks++;
    if (bcd !== 20'h255 || ovf !== 1'b0) begin
      errors++; $display("FAIL max_ff: got bcd=%h ovf=%b, want 255 0", bcd, ovf);
    end
    checks++;
    if (lat !== 9) begin
      errors++; $display("FAIL latency_8: got %0d, want 9", lat);
    end
    checks++;
    if (bc !== 8) begin
      errors++; $display("FAIL busy_cycles_8: got %0d, want 8", bc);
    end
  endtask

  task automatic test_small_values;
    logic [19:0] bcd; logic ovf; int lat, bc;
    logic [15:0] vin [3] = '{16'h00, 16'h07, 16'h64};
`ifdef BIN2BCD_BLANK_EN
    logic [19:0] vexp [3] = '{20'hFF0, 20'hFF7, 20'h100};
`else
    logic [19:0] vexp [3] = '{20'h000, 20'h007, 20'h100};
`endif
    for (int i = 0; i < 3; i++) begin
      run_conv(0, vin[i], bcd, ovf, lat, bc);
      checks++;
      if (bcd !== vexp[i] || ovf !== 1'b0) begin
        errors++; $display("FAIL small_%0d: got bcd=%h ovf=%b, want %h 0", vin[i], bcd, ovf, vexp[i]);
      end
    end
  endtask

  task automatic test_overflow;
    logic [19:0] bcd; logic ovf; int lat, bc;
    logic [15:0] vin [3]  = '{16'd99, 16'd100, 16'd255};
    logic [19:0] vexp [3] = '{20'h99, 20'h00, 20'h55};
    logic        oexp [3] = '{1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 3; i++) begin
      run_conv(1, vin[i], bcd, ovf, lat, bc);
      checks++;
      if (bcd !== vexp[i] || ovf !== oexp[i]) begin
        errors++;
        $display("FAIL ovf_%0d: got bcd=%h ovf=%b, want %h %b", vin[i], bcd, ovf, vexp[i], oexp[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    int n;
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_bin = 8'd123;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    n = 0;
    while (a_out_valid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    // Offer a new operand while the result is stalled; it must be ignored.
    a_in_valid = 1'b1; a_in_bin = 8'd5;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (a_out_valid !== 1'b1 || a_out_bcd !== 12'h123 || a_in_ready !== 1'b0 || a_busy !== 1'b0) begin
        errors++;
        $display("FAIL stall_cyc%0d: got vld=%b bcd=%h rdy=%b busy=%b, want 1 123 0 0",
                 i, a_out_valid, a_out_bcd, a_in_ready, a_busy);
      end
      @(posedge clk); #1;
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
      errors++; $display("FAIL release: got rdy=%b vld=%b, want 1 0", a_in_ready, a_out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (a_busy !== 1'b0 || a_in_ready !== 1'b1) begin
      errors++; $display("FAIL no_stale_capture: got busy=%b rdy=%b, want 0 1", a_busy, a_in_ready);
    end
    $display("backpressure: stalled result held, release ok");
  endtask

  task automatic test_reset_mid_shift;
    logic [19:0] bcd; logic ovf; int lat, bc;
    a_in_valid = 1'b1; a_in_bin = 8'd200;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (a_busy !== 1'b1) begin
      errors++; $display("FAIL pre_reset_busy: got %b, want 1", a_busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_busy !== 1'b0 || a_out_bcd !== 12'h0) begin
      errors++;
      $display("FAIL async_reset: got vld=%b rdy=%b busy=%b bcd=%h, want 0 1 0 000",
               a_out_valid, a_in_ready, a_busy, a_out_bcd);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_conv(0, 16'd42, bcd, ovf, lat, bc);
    checks++;
`ifdef BIN2BCD_BLANK_EN
    if (bcd !== 20'hF42 || ovf !== 1'b0) begin
      errors++; $display("FAIL after_reset_42: got bcd=%h ovf=%b, want f42 0", bcd, ovf);
    end
`else
    if (bcd !== 20'h042 || ovf !== 1'b0) begin
      errors++; $display("FAIL after_reset_42: got bcd=%h ovf=%b, want 042 0", bcd, ovf);
    end
`endif
  endtask

  task automatic test_wide;
    logic [19:0] bcd; logic ovf; int lat, bc;
    run_conv(2, 16'hFFFF, bcd, ovf, lat, bc);
    checks++;
    if (bcd !== 20'h65535 || ovf !== 1'b0) begin
      errors++; $display("FAIL wide_ffff: got bcd=%h ovf=%b, want 65535 0", bcd, ovf);
    end
    checks++;
    if (lat !== 17 || bc !== 16) begin
      errors++; $display("FAIL latency_16: got lat=%0d busy=%0d, want 17 16", lat, bc);
    end
    run_conv(2, 16'd10000, bcd, ovf, lat, bc);
    checks++;
    if (bcd !== 20'h10000 || ovf !== 1'b0) begin
      errors++; $display("FAIL wide_10000: got bcd=%h ovf=%b, want 10000 0", bcd, ovf);
    end
  endtask

  task automatic test_back_to_back;
    int prev, cnt, cyc;
`ifdef BIN2BCD_BLANK_EN
    logic [19:0] exp_bcd = 20'hF1234;
`else
    logic [19:0] exp_bcd = 20'h01234;
`endif
    prev = -1; cnt = 0; cyc = 0;
    c_in_valid = 1'b1; c_in_bin = 16'd1234;
    while (cnt < 3 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (c_out_valid === 1'b1) begin
        checks++;
        if (c_out_bcd !== exp_bcd) begin
          errors++; $display("FAIL b2b_value_%0d: got %h, want %h", cnt, c_out_bcd, exp_bcd);
        end
        if (prev >= 0) begin
          checks++;
          if (cyc - prev !== 18) begin
            errors++; $display("FAIL b2b_period_%0d: got %0d, want 18", cnt, cyc - prev);
          end
        end
        $display("b2b result %0d at cycle %0d bcd=%h", cnt, cyc, c_out_bcd);
        prev = cyc;
        cnt++;
      end
    end
    c_in_valid = 1'b0;
    checks++;
    if (cnt !== 3) begin
      errors++; $display("FAIL b2b_timeout: got %0d results, want 3", cnt);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    test_reset;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    test_max_value;
    test_small_values;
    test_overflow;
    test_backpressure;
    test_reset_mid_shift;
    test_wide;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
